hazard_stall_ctrl: RTL

//  Pipeline controller for the 5-stage MIPS core. Compares D-stage source-register demand (Tuse) with
//  E/M-stage producer timing (Tnew) and sequences the multiply/divide unit (MDU) busy window.

---
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core: Tuse/Tnew interlock plus MDU busy window.
// Optional STALL_STATS_EN macro adds a free-running stall_count output.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [4:0] D_rs_A,
    input  logic [4:0] D_rt_A,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic       D_is_md,
    input  logic       E_GRFWE,
    input  logic [4:0] E_GRF_A3,
    input  logic [1:0] E_Tnew,
    input  logic       M_GRFWE,
    input  logic [4:0] M_GRF_A3,
    input  logic [1:0] M_Tnew,
    input  logic       E_mdu_start,
    input  logic       E_mdu_is_div,
    output logic       F_en,
    output logic       D_en,
    output logic       E_clr,
    output logic       mdu_busy,
    output logic       mdu_done
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall_rs;
    logic             w_stall_rt;
    logic             w_stall_md;
    logic             w_stall;

    // Register 0 is hardwired and Tuse=3 marks an unused source, so neither can interlock.
    function automatic logic src_hazard(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic       we,
        input logic [4:0] a3,
        input logic [1:0] tnew
    );
        return (addr != 5'd0) && (tuse != 2'd3) && we && (a3 == addr) && (tuse < tnew);
    endfunction

    assign w_stall_rs = src_hazard(D_rs_A, D_Tuse_rs, E_GRFWE, E_GRF_A3, E_Tnew)
                      | src_hazard(D_rs_A, D_Tuse_rs, M_GRFWE, M_GRF_A3, M_Tnew);
    assign w_stall_rt = src_hazard(D_rt_A, D_Tuse_rt, E_GRFWE, E_GRF_A3, E_Tnew)
                      | src_hazard(D_rt_A, D_Tuse_rt, M_GRFWE, M_GRF_A3, M_Tnew);
    assign w_stall_md = D_is_md && (mdu_busy || E_mdu_start);
    assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

    assign F_en     = ~w_stall;
    assign D_en     = ~w_stall;
    assign E_clr    = w_stall;
    assign mdu_busy = (r_cnt != '0);
    assign mdu_done = (r_cnt == CNT_W'(1));

    // A start is only taken while idle, including the cycle the count has just drained to zero.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            if (E_mdu_start)
                r_cnt <= E_mdu_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (RESET)
            r_stall_count <= 32'd0;
        else if (w_stall)
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count = r_stall_count;
`endif

endmodule
